// File: rtl/tea_pkg.sv
// Shared constants and the controller state type for the iterative TEA engine.
package tea_pkg;

  localparam int unsigned TEA_WORD_SIZE    = 32;
  localparam int unsigned TEA_ROUND_NUMBER = 32;
  localparam logic [31:0] TEA_DELTA        = 32'h9e3779b9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } tea_state_e;

endpackage

// File: rtl/tea_round.sv
// One full TEA cycle (both half-rounds chained) as pure combinational logic.
// Optional TEA_DECRYPT_EN adds the inverse cycle selected by decrypt_i.
module tea_round
  import tea_pkg::*;
#(
  parameter int unsigned            WORD_SIZE = TEA_WORD_SIZE,
  parameter logic [WORD_SIZE-1:0]   DELTA     = WORD_SIZE'(TEA_DELTA)
) (
  input  logic [WORD_SIZE-1:0] v0_i,
  input  logic [WORD_SIZE-1:0] v1_i,
  input  logic [WORD_SIZE-1:0] sum_i,
  input  logic [WORD_SIZE-1:0] k0_i,
  input  logic [WORD_SIZE-1:0] k1_i,
  input  logic [WORD_SIZE-1:0] k2_i,
  input  logic [WORD_SIZE-1:0] k3_i,
`ifdef TEA_DECRYPT_EN
  input  logic                 decrypt_i,
`endif
  output logic [WORD_SIZE-1:0] v0_o,
  output logic [WORD_SIZE-1:0] v1_o,
  output logic [WORD_SIZE-1:0] sum_o
);

  function automatic logic [WORD_SIZE-1:0] tea_mix(
    input logic [WORD_SIZE-1:0] v,
    input logic [WORD_SIZE-1:0] ka,
    input logic [WORD_SIZE-1:0] kb,
    input logic [WORD_SIZE-1:0] s
  );
    tea_mix = ((v << 3'd4) + ka) ^ (v + s) ^ ((v >> 3'd5) + kb);
  endfunction

  logic [WORD_SIZE-1:0] sum_enc_s;
  logic [WORD_SIZE-1:0] v0_enc_s;
  logic [WORD_SIZE-1:0] v1_enc_s;

  // Encryption uses the updated sum and feeds the new v0 into the v1 half-round.
  assign sum_enc_s = sum_i + DELTA;
  assign v0_enc_s  = v0_i + tea_mix(v1_i, k0_i, k1_i, sum_enc_s);
  assign v1_enc_s  = v1_i + tea_mix(v0_enc_s, k2_i, k3_i, sum_enc_s);

`ifdef TEA_DECRYPT_EN
  logic [WORD_SIZE-1:0] sum_dec_s;
  logic [WORD_SIZE-1:0] v0_dec_s;
  logic [WORD_SIZE-1:0] v1_dec_s;

  // Decryption undoes the halves in reverse order with the current sum.
  assign v1_dec_s  = v1_i - tea_mix(v0_i, k2_i, k3_i, sum_i);
  assign v0_dec_s  = v0_i - tea_mix(v1_dec_s, k0_i, k1_i, sum_i);
  assign sum_dec_s = sum_i - DELTA;

  assign v0_o  = decrypt_i ? v0_dec_s  : v0_enc_s;
  assign v1_o  = decrypt_i ? v1_dec_s  : v1_enc_s;
  assign sum_o = decrypt_i ? sum_dec_s : sum_enc_s;
`else
  assign v0_o  = v0_enc_s;
  assign v1_o  = v1_enc_s;
  assign sum_o = sum_enc_s;
`endif

endmodule

// File: rtl/tea_cipher.sv
// One-shot iterative TEA engine: capture, one cycle per clock, sticky result.
// Optional macro TEA_DECRYPT_EN adds the iDecrypt input for TEA decryption.
module tea_cipher
  import tea_pkg::*;
#(
  parameter int unsigned          WORD_SIZE    = TEA_WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] DELTA        = WORD_SIZE'(TEA_DELTA),
  parameter int unsigned          ROUND_NUMBER = TEA_ROUND_NUMBER
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] iV0,
  input  logic [WORD_SIZE-1:0] iV1,
  input  logic [WORD_SIZE-1:0] iK0,
  input  logic [WORD_SIZE-1:0] iK1,
  input  logic [WORD_SIZE-1:0] iK2,
  input  logic [WORD_SIZE-1:0] iK3,
`ifdef TEA_DECRYPT_EN
  input  logic                 iDecrypt,
`endif
  output logic [WORD_SIZE-1:0] oC0,
  output logic [WORD_SIZE-1:0] oC1,
  output logic                 oDone
);

  localparam int unsigned    CW       = $clog2(ROUND_NUMBER + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(ROUND_NUMBER - 1);
`ifdef TEA_DECRYPT_EN
  localparam logic [WORD_SIZE-1:0] DEC_SUM = WORD_SIZE'(DELTA * ROUND_NUMBER);
  logic dec_q, dec_d;
`endif

  tea_state_e state_q, state_d;
  logic [WORD_SIZE-1:0] v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  logic [WORD_SIZE-1:0] k0_q, k0_d, k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
  logic [WORD_SIZE-1:0] oc0_q, oc0_d, oc1_q, oc1_d;
  logic                 done_q, done_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] rnd_v0_s, rnd_v1_s, rnd_sum_s;

  tea_round #(
    .WORD_SIZE (WORD_SIZE),
    .DELTA     (DELTA)
  ) u_round (
    .v0_i      (v0_q),
    .v1_i      (v1_q),
    .sum_i     (sum_q),
    .k0_i      (k0_q),
    .k1_i      (k1_q),
    .k2_i      (k2_q),
    .k3_i      (k3_q),
`ifdef TEA_DECRYPT_EN
    .decrypt_i (dec_q),
`endif
    .v0_o      (rnd_v0_s),
    .v1_o      (rnd_v1_s),
    .sum_o     (rnd_sum_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; LOAD is a single spacer cycle so the result lands R+1 edges after capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     state_d = (cnt_q == LAST_CNT) ? DONE : RUN;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next-values for each state.
  always_comb begin
    v0_d   = v0_q;
    v1_d   = v1_q;
    sum_d  = sum_q;
    k0_d   = k0_q;
    k1_d   = k1_q;
    k2_d   = k2_q;
    k3_d   = k3_q;
    cnt_d  = cnt_q;
    oc0_d  = oc0_q;
    oc1_d  = oc1_q;
    done_d = done_q;
`ifdef TEA_DECRYPT_EN
    dec_d  = dec_q;
`endif
    case (state_q)
      IDLE: begin
        v0_d   = iV0;
        v1_d   = iV1;
        k0_d   = iK0;
        k1_d   = iK1;
        k2_d   = iK2;
        k3_d   = iK3;
        cnt_d  = {CW{1'b0}};
        oc0_d  = {WORD_SIZE{1'b0}};
        oc1_d  = {WORD_SIZE{1'b0}};
        done_d = 1'b0;
`ifdef TEA_DECRYPT_EN
        dec_d  = iDecrypt;
        if (iDecrypt) begin
          sum_d = DEC_SUM;
        end else begin
          sum_d = {WORD_SIZE{1'b0}};
        end
`else
        sum_d  = {WORD_SIZE{1'b0}};
`endif
      end
      LOAD: begin
        cnt_d = {CW{1'b0}};
      end
      RUN: begin
        v0_d  = rnd_v0_s;
        v1_d  = rnd_v1_s;
        sum_d = rnd_sum_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          oc0_d  = rnd_v0_s;
          oc1_d  = rnd_v1_s;
          done_d = 1'b1;
        end else begin
          oc0_d  = {WORD_SIZE{1'b0}};
          oc1_d  = {WORD_SIZE{1'b0}};
          done_d = 1'b0;
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset clears everything, aborting any run.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q   <= {WORD_SIZE{1'b0}};
      v1_q   <= {WORD_SIZE{1'b0}};
      sum_q  <= {WORD_SIZE{1'b0}};
      k0_q   <= {WORD_SIZE{1'b0}};
      k1_q   <= {WORD_SIZE{1'b0}};
      k2_q   <= {WORD_SIZE{1'b0}};
      k3_q   <= {WORD_SIZE{1'b0}};
      cnt_q  <= {CW{1'b0}};
      oc0_q  <= {WORD_SIZE{1'b0}};
      oc1_q  <= {WORD_SIZE{1'b0}};
      done_q <= 1'b0;
`ifdef TEA_DECRYPT_EN
      dec_q  <= 1'b0;
`endif
    end else begin
      v0_q   <= v0_d;
      v1_q   <= v1_d;
      sum_q  <= sum_d;
      k0_q   <= k0_d;
      k1_q   <= k1_d;
      k2_q   <= k2_d;
      k3_q   <= k3_d;
      cnt_q  <= cnt_d;
      oc0_q  <= oc0_d;
      oc1_q  <= oc1_d;
      done_q <= done_d;
`ifdef TEA_DECRYPT_EN
      dec_q  <= dec_d;
`endif
    end
  end

  assign oC0   = oc0_q;
  assign oC1   = oc1_q;
  assign oDone = done_q;

endmodule

// File: tb/tb_tea_cipher.sv
// Self-checking bench for tea_cipher against a plain TEA reference loop.
// Exercises the TEA_DECRYPT_EN paths when that macro is defined.
module tb_tea_cipher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] iV0 = 32'd0, iV1 = 32'd0;
  logic [31:0] iK0 = 32'd0, iK1 = 32'd0, iK2 = 32'd0, iK3 = 32'd0;
`ifdef TEA_DECRYPT_EN
  logic        iDecrypt = 1'b0;
`endif
  logic [31:0] oC0, oC1;
  logic        oDone;

  int n_checks = 0;
  int n_errors = 0;

  tea_cipher dut (
    .clk      (clk),
    .rst      (rst),
    .iV0      (iV0),
    .iV1      (iV1),
    .iK0      (iK0),
    .iK1      (iK1),
    .iK2      (iK2),
    .iK3      (iK3),
`ifdef TEA_DECRYPT_EN
    .iDecrypt (iDecrypt),
`endif
    .oC0      (oC0),
    .oC1      (oC1),
    .oDone    (oDone)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference TEA as in the C reference: 32 cycles, sum stepping by delta.
  function automatic logic [63:0] tea_model(input logic [31:0] v0, input logic [31:0] v1,
                                            input logic [31:0] k0, input logic [31:0] k1,
                                            input logic [31:0] k2, input logic [31:0] k3,
                                            input bit dec);
    logic [31:0] y, z, s;
    y = v0;
    z = v1;
    if (!dec) begin
      s = 32'd0;
      for (int i = 0; i < 32; i++) begin
        s = s + 32'h9e3779b9;
        y = y + (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
        z = z + (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
      end
    end else begin
      s = 32'h9e3779b9 * 32'd32;
      for (int i = 0; i < 32; i++) begin
        z = z - (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
        y = y - (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
        s = s - 32'h9e3779b9;
      end
    end
    return {y, z};
  endfunction

  // Reset, present inputs, release; optionally disturb iV0/iK0 at a given cycle of the run.
  task automatic run_block(input string tag,
                           input logic [31:0] v0, input logic [31:0] v1,
                           input logic [31:0] k0, input logic [31:0] k1,
                           input logic [31:0] k2, input logic [31:0] k3,
                           input bit dec, input int perturb_at,
                           output logic [63:0] result);
    int lat;
    @(negedge clk);
    rst = 1'b1;
    iV0 = v0; iV1 = v1; iK0 = k0; iK1 = k1; iK2 = k2; iK3 = k3;
`ifdef TEA_DECRYPT_EN
    iDecrypt = dec;
`endif
    @(negedge clk);
    check_value({tag, "_in_reset"}, {31'd0, oDone, oC0, oC1} & 64'h0, 64'd0);
    check_value({tag, "_reset_out"}, {oC0, oC1}, 64'd0);
    rst = 1'b0;
    @(posedge clk);  // capture edge E0
    #1;
    check_value({tag, "_done_after_capture"}, {63'd0, oDone}, 64'd0);
    lat = 0;
    while (!oDone && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == perturb_at) begin
        iV0 = $urandom;
        iK0 = $urandom;
      end
      if (!oDone) begin
        if ((lat % 8) == 0) check_value({tag, "_run_outputs_zero"}, {oC0, oC1}, 64'd0);
      end
    end
    check_value({tag, "_latency"}, 64'(lat), 64'd33);
    result = {oC0, oC1};
  endtask

  initial begin
    logic [63:0] res, res2, exp;
    logic [31:0] r0, r1, a0, a1, a2, a3;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_value("reset_state", {31'd0, oDone, oC0, oC1} , 64'd0);
    check_value("reset_done", {63'd0, oDone}, 64'd0);

    // Known zero-key vector
    run_block("zero", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, -1, res);
    check_value("zero_vector", res, 64'h41ea3a0a_94baa940);
    check_value("zero_model", res, tea_model(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0));

    // Published-key vector, then stability in DONE while inputs churn
    exp = tea_model(32'h3d45f7a7, 32'h235fcb21, 32'h132acf42, 32'h234acb45,
                    32'h3235acbe, 32'h4533f235, 1'b0);
    run_block("key", 32'h3d45f7a7, 32'h235fcb21, 32'h132acf42, 32'h234acb45,
              32'h3235acbe, 32'h4533f235, 1'b0, -1, res);
    check_value("key_vector", res, exp);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      iV0 = $urandom; iV1 = $urandom; iK0 = $urandom; iK3 = $urandom;
      if ((i % 25) == 0) begin
        check_value("done_stable", {31'd0, oDone, oC0, oC1}, {31'd0, 1'b1, exp});
      end
    end

    // Reset from DONE clears outputs on that very edge
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_value("reset_from_done", {31'd0, oDone, oC0, oC1}, 64'd0);
    check_value("reset_from_done_flag", {63'd0, oDone}, 64'd0);

    // Abort mid-run, then a fresh encryption with new plaintext
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_value("abort_clear", {31'd0, oDone, oC0, oC1}, 64'd0);
    a0 = $urandom; a1 = $urandom; a2 = $urandom; a3 = $urandom;
    r0 = $urandom; r1 = $urandom;
    run_block("after_abort", r0, r1, a0, a1, a2, a3, 1'b0, -1, res);
    check_value("after_abort_result", res, tea_model(r0, r1, a0, a1, a2, a3, 1'b0));

    // Inputs disturbed during RUN must not matter
    r0 = $urandom; r1 = $urandom;
    run_block("perturb", r0, r1, a0, a1, a2, a3, 1'b0, 5, res);
    check_value("perturb_result", res, tea_model(r0, r1, a0, a1, a2, a3, 1'b0));

    // Random vectors
    for (int n = 0; n < 6; n++) begin
      a0 = $urandom; a1 = $urandom; a2 = $urandom; a3 = $urandom;
      r0 = $urandom; r1 = $urandom;
      run_block("rand", r0, r1, a0, a1, a2, a3, 1'b0, -1, res);
      check_value("rand_result", res, tea_model(r0, r1, a0, a1, a2, a3, 1'b0));
    end

`ifdef TEA_DECRYPT_EN
    run_block("dec_zero", 32'h41ea3a0a, 32'h94baa940, 32'd0, 32'd0, 32'd0, 32'd0,
              1'b1, -1, res);
    check_value("dec_zero_result", res, 64'd0);
    for (int n = 0; n < 4; n++) begin
      a0 = $urandom; a1 = $urandom; a2 = $urandom; a3 = $urandom;
      r0 = $urandom; r1 = $urandom;
      run_block("rt_enc", r0, r1, a0, a1, a2, a3, 1'b0, -1, res);
      check_value("rt_enc_result", res, tea_model(r0, r1, a0, a1, a2, a3, 1'b0));
      run_block("rt_dec", res[63:32], res[31:0], a0, a1, a2, a3, 1'b1, -1, res2);
      check_value("rt_roundtrip", res2, {r0, r1});
      check_value("rt_dec_model", res2, tea_model(res[63:32], res[31:0], a0, a1, a2, a3, 1'b1));
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
